// File: rtl/seq_det_pkg.sv
// Shared types, widths and small helpers for the sequence-scan controller.
// Imported by the interface, the top and the pattern matcher.
package seq_det_pkg;

  localparam int HIST_W = 4;
  localparam int SCAN_W = 8;
  localparam int IDX_W  = $clog2(SCAN_W);
  localparam int CNT_W  = $clog2(HIST_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HIST_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_e;

  // Selects the active low-order bits of the pattern for a given length code.
  function automatic logic [HIST_W-1:0] len_mask(input logic [1:0] len);
    logic [HIST_W-1:0] m;
    case (len)
      2'd0:    m = 4'b0001;
      2'd1:    m = 4'b0011;
      2'd2:    m = 4'b0111;
      2'd3:    m = 4'b1111;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Byte-load handshake, scan configuration and result bus of the scan controller.
interface seq_scan_ctrl_if;
  import seq_det_pkg::*;

  logic              load_valid;
  logic [SCAN_W-1:0] load_data;
  logic              load_ready;
  logic [HIST_W-1:0] cfg_pattern;
  logic [1:0]        cfg_len;
  logic              cfg_overlap;
  logic              clear_hist;
  logic              match;
  logic              done;
  logic [SCAN_W-1:0] match_vec;
  logic [7:0]        match_count;

  modport master (
    output load_valid, load_data, cfg_pattern, cfg_len, cfg_overlap, clear_hist,
    input  load_ready, match, done, match_vec, match_count
  );

  modport slave (
    input  load_valid, load_data, cfg_pattern, cfg_len, cfg_overlap, clear_hist,
    output load_ready, match, done, match_vec, match_count
  );

endinterface

// File: rtl/pattern_match_core.sv
// Bit-serial pattern detector: 4-bit history (newest at LSB), saturating
// valid-bit count and a registered Moore match flag.
module pattern_match_core
  import seq_det_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_in,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [HIST_W-1:0] pattern,
  input  logic [1:0]        len,
  input  logic              overlap,
  output logic              hit,
  output logic              match
);

  logic [HIST_W-1:0] hist_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              match_r;
  logic [HIST_W-1:0] base_hist_s;
  logic [CNT_W-1:0]  base_cnt_s;
  logic [HIST_W-1:0] shifted_s;
  logic [CNT_W-1:0]  cnt_inc_s;
  logic [CNT_W-1:0]  need_s;
  logic [HIST_W-1:0] hist_s;
  logic [CNT_W-1:0]  cnt_s;
  logic              hit_s;

  // A clear empties the history first, so a bit shifted in the same cycle
  // lands in an empty history and may itself complete a 1-bit pattern.
  always_comb begin
    base_hist_s = {HIST_W{1'b0}};
    base_cnt_s  = {CNT_W{1'b0}};
    if (clear) begin
      base_hist_s = {HIST_W{1'b0}};
      base_cnt_s  = {CNT_W{1'b0}};
    end else begin
      base_hist_s = hist_r;
      base_cnt_s  = cnt_r;
    end

    shifted_s = {base_hist_s[HIST_W-2:0], bit_in};
    if (base_cnt_s == CNT_MAX) begin
      cnt_inc_s = CNT_MAX;
    end else begin
      cnt_inc_s = base_cnt_s + 3'd1;
    end
    need_s = {1'b0, len} + 3'd1;

    hit_s = shift_en && (cnt_inc_s >= need_s) &&
            (((shifted_s ^ pattern) & len_mask(len)) == {HIST_W{1'b0}});

    hist_s = base_hist_s;
    cnt_s  = base_cnt_s;
    if (shift_en) begin
      hist_s = shifted_s;
      if (hit_s && !overlap) begin
        cnt_s = {CNT_W{1'b0}};
      end else begin
        cnt_s = cnt_inc_s;
      end
    end else begin
      hist_s = base_hist_s;
      cnt_s  = base_cnt_s;
    end
  end

  // History, count and match flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_r  <= {HIST_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      match_r <= 1'b0;
    end else begin
      hist_r  <= hist_s;
      cnt_r   <= cnt_s;
      match_r <= hit_s;
    end
  end

  assign hit   = hit_s;
  assign match = match_r;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-at-a-time scan controller: accepts a byte, feeds its bits LSB-first into
// the pattern matcher, and reports a per-bit match vector plus a running count.
module seq_scan_ctrl
  import seq_det_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  seq_scan_ctrl_if.slave bus
);

  scan_state_e       state_r;
  scan_state_e       state_s;
  logic [SCAN_W-1:0] data_r;
  logic [HIST_W-1:0] pattern_r;
  logic [1:0]        len_r;
  logic              overlap_r;
  logic [IDX_W-1:0]  idx_r;
  logic              accept_s;
  logic              shift_s;
  logic              bit_s;
  logic              hit_s;
  logic              match_s;
  logic              load_ready_r;
  logic              done_r;
  logic [SCAN_W-1:0] vec_r;
  logic [7:0]        count_r;

  // Next-state decode; a byte is taken only in IDLE, anything else is ignored.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    shift_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.load_valid) begin
          state_s  = ST_SHIFT;
          accept_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        shift_s = 1'b1;
        if (idx_r == 3'd7) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    bit_s = data_r[idx_r];
  end

  // State register plus the byte and configuration frozen at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      data_r    <= {SCAN_W{1'b0}};
      pattern_r <= {HIST_W{1'b0}};
      len_r     <= 2'd0;
      overlap_r <= 1'b0;
      idx_r     <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        data_r    <= bus.load_data;
        pattern_r <= bus.cfg_pattern;
        len_r     <= bus.cfg_len;
        overlap_r <= bus.cfg_overlap;
        idx_r     <= {IDX_W{1'b0}};
      end else if (shift_s) begin
        idx_r <= idx_r + 3'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  pattern_match_core u_core (
    .clk      (clk),
    .reset    (reset),
    .bit_in   (bit_s),
    .shift_en (shift_s),
    .clear    (bus.clear_hist),
    .pattern  (pattern_r),
    .len      (len_r),
    .overlap  (overlap_r),
    .hit      (hit_s),
    .match    (match_s)
  );

  // Results are updated on the same edge as the match flag so that a match on
  // the last bit is already folded into match_vec when done rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_ready_r <= 1'b1;
      done_r       <= 1'b0;
      vec_r        <= {SCAN_W{1'b0}};
      count_r      <= 8'd0;
    end else begin
      load_ready_r <= (state_s == ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      if (accept_s) begin
        vec_r <= {SCAN_W{1'b0}};
      end else if (hit_s) begin
        vec_r[idx_r] <= 1'b1;
      end else begin
        vec_r <= vec_r;
      end
      if (hit_s) begin
        count_r <= sat_inc8(count_r);
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign bus.load_ready  = load_ready_r;
  assign bus.done        = done_r;
  assign bus.match       = match_s;
  assign bus.match_vec   = vec_r;
  assign bus.match_count = count_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus random bytes
// compared against a bit-stream reference model.
module tb_seq_scan_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  logic mq[$];
  int   model_cnt;

  seq_scan_ctrl_if bus ();

  seq_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    mq.delete();
    model_cnt = 0;
  endfunction

  // The input is one continuous bit stream; mq holds the bits since the last
  // discard point (reset, clear, or a non-overlapping match), trimmed to 4.
  function automatic void model_byte(input logic [7:0] d, input logic [3:0] p,
                                     input logic [1:0] l, input logic o,
                                     input int clr_at, output logic [7:0] vec);
    int len_bits;
    bit ok;
    len_bits = int'(l) + 1;
    vec = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (clr_at == i + 1) mq.delete();
      mq.push_back(d[i]);
      if (mq.size() > 4) void'(mq.pop_front());
      if (mq.size() >= len_bits) begin
        ok = 1'b1;
        for (int j = 0; j < len_bits; j++)
          if (mq[mq.size() - len_bits + j] !== p[len_bits - 1 - j]) ok = 1'b0;
        if (ok) begin
          vec[i] = 1'b1;
          if (model_cnt < 255) model_cnt++;
          if (!o) mq.delete();
        end
      end
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.load_valid = 1'b0;
    bus.clear_hist = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clear_hist = 1'b1;
    @(negedge clk);
    bus.clear_hist = 1'b0;
    mq.delete();
  endtask

  // Offers one byte and records match/done/load_ready for cycles T1..T10
  // (bit k-1 of each vector is cycle Tk); results are sampled at T9.
  task automatic run_byte(input logic [7:0] d, input logic [3:0] p, input logic [1:0] l,
                          input logic o, input int clr_at,
                          output logic [9:0] m_tl, output logic [9:0] d_tl,
                          output logic [9:0] r_tl, output logic [7:0] vec9,
                          output logic [7:0] cnt9);
    int waits;
    waits = 0;
    m_tl = 10'd0; d_tl = 10'd0; r_tl = 10'd0; vec9 = 8'd0; cnt9 = 8'd0;
    @(negedge clk);
    while (!bus.load_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    total++;
    if (bus.load_ready !== 1'b1) $display("FAIL ready_timeout: load_ready=%b want 1", bus.load_ready);
    else passed++;
    bus.load_valid  = 1'b1;
    bus.load_data   = d;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.load_valid = 1'b0;
      bus.clear_hist = (k == clr_at);
      m_tl[k-1] = bus.match;
      d_tl[k-1] = bus.done;
      r_tl[k-1] = bus.load_ready;
      if (k == 9) begin
        vec9 = bus.match_vec;
        cnt9 = bus.match_count;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (bus.load_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.load_ready); else passed++;
    total++; if (bus.match !== 1'b0) $display("FAIL reset_match: got %b want 0", bus.match); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
    total++; if (bus.match_vec !== 8'h00) $display("FAIL reset_vec: got %h want 00", bus.match_vec); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus.match_count); else passed++;
  endtask

  task automatic test_overlap();
    logic [9:0] m, dn, r;
    logic [7:0] v, c;
    do_reset();
    run_byte(8'h6D, 4'b1011, 2'd3, 1'b1, 0, m, dn, r, v, c);
    total++; if (v !== 8'h48) $display("FAIL ovl_vec: got %h want 48", v); else passed++;
    total++; if (c !== 8'd2) $display("FAIL ovl_count: got %0d want 2", c); else passed++;
    total++; if (m !== {1'b0, 8'h48, 1'b0}) $display("FAIL ovl_match_timing: got %b want %b", m, {1'b0, 8'h48, 1'b0}); else passed++;
    total++; if (dn !== 10'b01_0000_0000) $display("FAIL ovl_done_T9: got %b want 0100000000", dn); else passed++;
    total++; if (r !== 10'b10_0000_0000) $display("FAIL ovl_ready: got %b want 1000000000", r); else passed++;
  endtask

  task automatic test_nonoverlap();
    logic [9:0] m, dn, r;
    logic [7:0] v, c;
    do_reset();
    run_byte(8'h6D, 4'b1011, 2'd3, 1'b0, 0, m, dn, r, v, c);
    total++; if (v !== 8'h08) $display("FAIL novl_vec: got %h want 08", v); else passed++;
    total++; if (c !== 8'd1) $display("FAIL novl_count: got %0d want 1", c); else passed++;
  endtask

  task automatic test_stream();
    logic [9:0] m, dn, r;
    logic [7:0] v, c, ev;
    do_reset();
    model_byte(8'h80, 4'b1011, 2'd3, 1'b1, 0, ev);
    run_byte(8'h80, 4'b1011, 2'd3, 1'b1, 0, m, dn, r, v, c);
    total++; if (v !== 8'h00) $display("FAIL stream_vec1: got %h want 00", v); else passed++;
    model_byte(8'h06, 4'b1011, 2'd3, 1'b1, 0, ev);
    run_byte(8'h06, 4'b1011, 2'd3, 1'b1, 0, m, dn, r, v, c);
    total++; if (v !== 8'h04) $display("FAIL stream_vec2: got %h want 04", v); else passed++;
  endtask

  task automatic test_clear();
    logic [9:0] m, dn, r;
    logic [7:0] v, c, ev;
    pulse_clear();
    model_byte(8'h00, 4'b0000, 2'd3, 1'b1, 0, ev);
    run_byte(8'h00, 4'b0000, 2'd3, 1'b1, 0, m, dn, r, v, c);
    total++; if (v !== 8'hF8) $display("FAIL clear_vec: got %h want f8", v); else passed++;
    total++; if (m[3:0] !== 4'b0000) $display("FAIL clear_early_match: got %b want 0000", m[3:0]); else passed++;
    total++; if (c !== 8'(model_cnt)) $display("FAIL clear_count: got %0d want %0d", c, model_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [18:0] r, dn;
    logic [7:0]  v1, v2, c, e1, e2;
    do_reset();
    model_byte(8'h6D, 4'b1011, 2'd3, 1'b1, 0, e1);
    model_byte(8'h6D, 4'b1011, 2'd3, 1'b1, 0, e2);
    r = 19'd0; dn = 19'd0; v1 = 8'd0; v2 = 8'd0; c = 8'd0;
    @(negedge clk);
    bus.load_valid  = 1'b1;
    bus.load_data   = 8'h6D;
    bus.cfg_pattern = 4'b1011;
    bus.cfg_len     = 2'd3;
    bus.cfg_overlap = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      r[k-1]  = bus.load_ready;
      dn[k-1] = bus.done;
      if (k == 9) v1 = bus.match_vec;
      if (k == 11) bus.load_valid = 1'b0;
      if (k == 19) begin
        v2 = bus.match_vec;
        c  = bus.match_count;
      end
    end
    total++; if (r !== 19'h00200) $display("FAIL b2b_ready: got %h want 00200", r); else passed++;
    total++; if (dn !== 19'h40100) $display("FAIL b2b_done: got %h want 40100", dn); else passed++;
    total++; if (v1 !== e1) $display("FAIL b2b_vec1: got %h want %h", v1, e1); else passed++;
    total++; if (v2 !== e2) $display("FAIL b2b_vec2: got %h want %h", v2, e2); else passed++;
    total++; if (c !== 8'(model_cnt)) $display("FAIL b2b_count: got %0d want %0d", c, model_cnt); else passed++;
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    do_reset();
    saw_done = 1'b0;
    @(negedge clk);
    bus.load_valid  = 1'b1;
    bus.load_data   = 8'h6D;
    bus.cfg_pattern = 4'b1011;
    bus.cfg_len     = 2'd3;
    bus.cfg_overlap = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.load_valid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++; if (bus.load_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus.load_ready); else passed++;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    total++; if (saw_done !== 1'b0) $display("FAIL abort_done: got %b want 0", saw_done); else passed++;
    total++; if (bus.match_count !== 8'd0) $display("FAIL abort_count: got %0d want 0", bus.match_count); else passed++;
    total++; if (bus.match_vec !== 8'h00) $display("FAIL abort_vec: got %h want 00", bus.match_vec); else passed++;
  endtask

  task automatic test_saturation();
    logic [9:0] m, dn, r;
    logic [7:0] v, c, ev;
    do_reset();
    for (int n = 0; n < 34; n++) begin
      model_byte(8'hFF, 4'b0001, 2'd0, 1'b1, 0, ev);
      run_byte(8'hFF, 4'b0001, 2'd0, 1'b1, 0, m, dn, r, v, c);
    end
    total++; if (c !== 8'd255) $display("FAIL sat_count: got %0d want 255", c); else passed++;
    total++; if (v !== ev) $display("FAIL sat_vec: got %h want %h", v, ev); else passed++;
  endtask

  task automatic test_random();
    logic [9:0] m, dn, r;
    logic [7:0] v, c, ev, d;
    logic [3:0] p;
    logic [1:0] l;
    logic       o;
    int         clr_at;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom());
      p = 4'($urandom());
      l = 2'($urandom());
      o = 1'($urandom());
      clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      if ($urandom_range(0, 4) == 0) pulse_clear();
      model_byte(d, p, l, o, clr_at, ev);
      run_byte(d, p, l, o, clr_at, m, dn, r, v, c);
      total++; if (v !== ev) $display("FAIL rand_vec[%0d]: got %h want %h (d=%h p=%b l=%0d o=%b clr=%0d)", n, v, ev, d, p, l, o, clr_at); else passed++;
      total++; if (m !== {1'b0, ev, 1'b0}) $display("FAIL rand_match[%0d]: got %b want %b", n, m, {1'b0, ev, 1'b0}); else passed++;
      total++; if (c !== 8'(model_cnt)) $display("FAIL rand_count[%0d]: got %0d want %0d", n, c, model_cnt); else passed++;
      total++; if (dn !== 10'b01_0000_0000) $display("FAIL rand_done[%0d]: got %b want 0100000000", n, dn); else passed++;
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_data   = 8'h00;
    bus.cfg_pattern = 4'h0;
    bus.cfg_len     = 2'd0;
    bus.cfg_overlap = 1'b0;
    bus.clear_hist  = 1'b0;
    model_reset();
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_stream();
    test_clear();
    test_back_to_back();
    test_reset_abort();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_scan_ctrl.md
SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: load_valid  in  1  byte offered for scanning.
REQ-004 SHALL have: load_data  in  8  byte to scan; bit 0 is scanned first.
REQ-005 SHALL have: load_ready  out  1  controller can accept a byte.
REQ-006 SHALL have: cfg_pattern  in  4  target pattern; the first-received bit is the MSB of the active field.
REQ-007 SHALL have: cfg_len  in  2  pattern length minus 1 (1..4 bits).
REQ-008 SHALL have: cfg_overlap  in  1  1 = overlapping detection, 0 = history discarded after a match.
REQ-009 SHALL have: clear_hist  in  1  discard detector history.
REQ-010 SHALL have: match  out  1  Moore detect flag, one cycle per match.
REQ-011 SHALL have: done  out  1  one-cycle pulse when a byte scan completes.
REQ-012 SHALL have: match_vec  out  8  bit i = pattern completed on scanned bit i; valid with done.
REQ-013 SHALL have: match_count  out  8  saturating total matches since reset.

Function
REQ-014 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; load_ready = 1 only in IDLE.
REQ-015 SHALL accept a byte on load_valid & load_ready (cycle T0), capturing load_data, cfg_pattern, cfg_len and cfg_overlap; config is stable for the whole byte.
REQ-016 SHALL shift captured bit i into the detector in cycle T(i+1), i = 0..7, then enter DONE at T9 and return to IDLE at T10.
REQ-017 SHALL keep a 4-bit history (newest bit at LSB) and a valid-bit count saturating at 4; a match requires count >= L and hist[L-1:0] == cfg_pattern[L-1:0], where L = cfg_len+1.
REQ-018 SHALL register match, so a match on bit i is visible in the cycle after that bit is shifted; a match on bit 7 is visible at T9, together with done.
REQ-019 SHALL, when cfg_overlap = 0, reset the valid-bit count to 0 after a match; when it is 1, the history is retained.
REQ-020 SHALL carry history across bytes, treating the input as one continuous stream.
REQ-021 SHALL zero the history and count on clear_hist in any state; if a bit shifts in the same cycle, it enters the emptied history (count = 1).
REQ-022 SHALL clear match_vec at acceptance, set bit i on each match, and present the final value with done; it holds until the next acceptance.
REQ-023 SHALL increment match_count per match, saturating at 255.
REQ-024 SHALL ignore load_valid outside IDLE; there is no queuing.

Reset
REQ-025 SHALL, on reset, go to IDLE and clear the history, valid-bit count, match, done, match_vec and match_count; load_ready = 1 from the first cycle after reset.
REQ-026 SHALL abort a scan if reset is applied mid-SHIFT: no done pulse, and the partial results are discarded.

Structure
REQ-027 SHALL place state encodings (IDLE/SHIFT/DONE), the history width 4 and the scan width 8 in the shared package seq_det_pkg.
REQ-028 SHALL put the history/match logic in sub-module pattern_match_core (inputs: bit, shift enable, clear, pattern, length, overlap; output: registered match).

Verification
REQ-029 SHALL check reset: all outputs 0, load_ready = 1, match_count = 0.
REQ-030 SHALL check pattern 1011, len 3, overlap 1, byte 0x6D -> match after bits 3 and 6, match_vec = 0x48, match_count = 2, done at T9.
REQ-031 SHALL check the same stimulus with overlap 0 -> match_vec = 0x08, match_count = 1.
REQ-032 SHALL check stream continuity, pattern 1011: byte 0x80 then byte 0x06 -> first match_vec = 0x00, second = 0x04.
REQ-033 SHALL check clear_hist, then pattern 0000, len 3, overlap 1, byte 0x00 -> match_vec = 0xF8, with no matches on bits 0-2.
REQ-034 SHALL check load_valid held high continuously: load_ready = 0 for T1..T9 and the second byte is accepted at T10; separately, reset at T4 gives no done and match_count = 0.
